// File: rtl/video_system_onchip_memory_arbiter_pkg.sv
// Shared types and constants for the on-chip memory arbiter.
//
// Contents:
//   master_id_t       - identifies a requester (0 = CPU data master, 1 = pixel/DMA master)
//   MAX_READ_LATENCY  - deepest RAM read latency the tag pipeline supports
//   read_tag_t        - one stage of the read-return pipeline {valid, id}
//   idToOneHot        - converts a master id into a one-hot grant vector
package video_system_mem_arb_pkg;

   typedef logic master_id_t;

   localparam int MAX_READ_LATENCY = 4;

   typedef struct packed {
      logic       valid;
      master_id_t id;
   } read_tag_t;

   function automatic logic [1:0] idToOneHot(master_id_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/video_system_onchip_memory_arbiter_rr_arbiter2.sv
// Two-requester combinational arbiter.
//
// A lone requester always wins. When both request, m0 wins if fixed
// priority is selected; otherwise the master that did not win last time
// (the one not named by last_grant_i) wins.
//
// Ports:
//   req_i            [1:0] request vector, bit i = master i
//   last_grant_i           index of the most recently granted master
//   fixed_priority_i       1 = m0 always wins contention
//   grant_o          [1:0] one-hot grant (all zero when nobody requests)
module video_system_rr_arbiter2
   import video_system_mem_arb_pkg::*;
(
   input  logic [1:0] req_i,
   input  master_id_t last_grant_i,
   input  logic       fixed_priority_i,
   output logic [1:0] grant_o
);

   // Contention resolves to the master opposite last_grant_i, so a
   // last_grant of 1 (the reset value) favours m0 on the first tie.
   always_comb begin
      grant_o = 2'b00;
      case (req_i)
         2'b01:   grant_o = 2'b01;
         2'b10:   grant_o = 2'b10;
         2'b11: begin
            if (fixed_priority_i) begin
               grant_o = 2'b01;
            end else begin
               grant_o = idToOneHot(~last_grant_i);
            end
         end
         default: grant_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/video_system_onchip_memory_arbiter.sv
// Two-port Avalon-MM arbiter sharing the single-port 4096x32 on-chip RAM
// between m0 (CPU data master) and m1 (pixel/DMA master).
//
// One transfer is granted per cycle. Read data returns to the requester
// that issued it through a {valid, id} tag pipeline whose depth matches
// the RAM read latency, so back-to-back reads return in issue order.
//
// Ports:
//   clk, reset                  system clock, synchronous active-high reset
//   m0_* / m1_*                 Avalon-MM slave side for each requester
//                               (address, byteenable, read, write, writedata,
//                                waitrequest, readdata, readdatavalid)
//   mem_address/byteenable/
//   mem_chipselect/write/
//   mem_writedata/clken         RAM control and write path
//   mem_readdata                RAM read data, fanned out to both masters
module video_system_onchip_memory_arbiter
   import video_system_mem_arb_pkg::*;
#(
   parameter int ADDR_W         = 12,
   parameter int DATA_W         = 32,
   parameter int BE_W           = 4,
   parameter int READ_LATENCY   = 1,
   parameter int FIXED_PRIORITY = 0
) (
   input  logic              clk,
   input  logic              reset,

   input  logic [ADDR_W-1:0] m0_address,
   input  logic [BE_W-1:0]   m0_byteenable,
   input  logic              m0_read,
   input  logic              m0_write,
   input  logic [DATA_W-1:0] m0_writedata,
   output logic              m0_waitrequest,
   output logic [DATA_W-1:0] m0_readdata,
   output logic              m0_readdatavalid,

   input  logic [ADDR_W-1:0] m1_address,
   input  logic [BE_W-1:0]   m1_byteenable,
   input  logic              m1_read,
   input  logic              m1_write,
   input  logic [DATA_W-1:0] m1_writedata,
   output logic              m1_waitrequest,
   output logic [DATA_W-1:0] m1_readdata,
   output logic              m1_readdatavalid,

   output logic [ADDR_W-1:0] mem_address,
   output logic [BE_W-1:0]   mem_byteenable,
   output logic              mem_chipselect,
   output logic              mem_write,
   output logic [DATA_W-1:0] mem_writedata,
   output logic              mem_clken,
   input  logic [DATA_W-1:0] mem_readdata
);

   // Out-of-range latencies are clamped so the pipeline always has at
   // least one stage and never exceeds what the RAM can be built with.
   localparam int LAT = (READ_LATENCY < 1) ? 1 :
                        (READ_LATENCY > MAX_READ_LATENCY) ? MAX_READ_LATENCY :
                        READ_LATENCY;

   logic [1:0]        req;
   logic [1:0]        grantRaw;
   logic [1:0]        grant;
   logic              anyGrant;
   logic              m0IsRead;
   logic              m1IsRead;

   master_id_t        lastGrant_q;
   master_id_t        lastGrant_d;

   logic [ADDR_W-1:0] addrHold_q;
   logic [BE_W-1:0]   beHold_q;
   logic [DATA_W-1:0] wdataHold_q;

   logic [ADDR_W-1:0] muxAddr;
   logic [BE_W-1:0]   muxBe;
   logic [DATA_W-1:0] muxWdata;

   read_tag_t         tagIn;
   read_tag_t         tagOut;
   read_tag_t         tagPipe_q [LAT];

   // A write on the same master wins over a simultaneous read, so a read
   // only counts when write is low.
   assign req[0]   = m0_read | m0_write;
   assign req[1]   = m1_read | m1_write;
   assign m0IsRead = m0_read & ~m0_write;
   assign m1IsRead = m1_read & ~m1_write;

   video_system_rr_arbiter2 u_arbiter (
      .req_i            (req),
      .last_grant_i     (lastGrant_q),
      .fixed_priority_i (FIXED_PRIORITY != 0),
      .grant_o          (grantRaw)
   );

   // Nothing is granted while reset is held, which keeps chipselect low
   // and both waitrequests high for the whole reset window.
   assign grant    = reset ? 2'b00 : grantRaw;
   assign anyGrant = |grant;

   assign m0_waitrequest = reset | (req[0] & ~grant[0]);
   assign m1_waitrequest = reset | (req[1] & ~grant[1]);

   // Address/byteenable/writedata select follows the grant; when idle the
   // last granted values are replayed so the RAM inputs stay quiet.
   always_comb begin
      muxAddr  = addrHold_q;
      muxBe    = beHold_q;
      muxWdata = wdataHold_q;
      if (grant[1]) begin
         muxAddr  = m1_address;
         muxBe    = m1_byteenable;
         muxWdata = m1_writedata;
      end else if (grant[0]) begin
         muxAddr  = m0_address;
         muxBe    = m0_byteenable;
         muxWdata = m0_writedata;
      end
   end

   assign mem_address    = reset ? '0 : muxAddr;
   assign mem_byteenable = reset ? '0 : muxBe;
   assign mem_writedata  = reset ? '0 : muxWdata;
   assign mem_chipselect = anyGrant;
   assign mem_write      = (grant[0] & m0_write) | (grant[1] & m1_write);
   assign mem_clken      = ~reset;

   // Only granted cycles move last_grant; idle cycles leave the round-robin
   // pointer where it was.
   always_comb begin
      lastGrant_d = lastGrant_q;
      if (anyGrant) begin
         lastGrant_d = grant[1];
      end
   end

   // A tag enters the pipeline for every granted read; every other cycle
   // pushes an empty stage so returns stay aligned with the RAM.
   always_comb begin
      tagIn       = '0;
      tagIn.valid = (grant[0] & m0IsRead) | (grant[1] & m1IsRead);
      tagIn.id    = grant[1];
   end

   // Round-robin pointer, idle hold registers and the read-tag shift
   // register. Reset empties the pipeline so in-flight reads are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastGrant_q <= 1'b1;
         addrHold_q  <= '0;
         beHold_q    <= '0;
         wdataHold_q <= '0;
         for (int s = 0; s < LAT; s++) begin
            tagPipe_q[s] <= '0;
         end
      end else begin
         lastGrant_q <= lastGrant_d;
         if (anyGrant) begin
            addrHold_q  <= muxAddr;
            beHold_q    <= muxBe;
            wdataHold_q <= muxWdata;
         end
         tagPipe_q[0] <= tagIn;
         for (int s = 1; s < LAT; s++) begin
            tagPipe_q[s] <= tagPipe_q[s-1];
         end
      end
   end

   assign tagOut = tagPipe_q[LAT-1];

   // Read data is shared; the tag at the last stage picks who sees valid.
   assign m0_readdata      = mem_readdata;
   assign m1_readdata      = mem_readdata;
   assign m0_readdatavalid = ~reset & tagOut.valid & (tagOut.id == 1'b0);
   assign m1_readdatavalid = ~reset & tagOut.valid & (tagOut.id == 1'b1);

endmodule
